ysyx_regfile_sb: RTL and testbench
==================================

Name: ysyx_regfile_sb

Overview:
Parametrised integer register file for the ysyx core, successor to the basic 2R1W array. It adds a hardwired-zero register, optional write-to-read bypass, and a post-reset clear sweep with a ready flag. It also carries a per-register pending-write scoreboard used by decode/issue for RAW hazard detection. It sits between decode (read/issue) and writeback (write/retire).

Parameters:
XLEN, 32, data width in bits
NREG, 32, number of architectural registers (power of two, >=2); AW = log2(NREG) localparam
ZERO_REG, 1, 1: register 0 reads 0 and ignores writes and issues; 0: register 0 is ordinary
BYPASS, 1, 1: same-cycle write data is forwarded to matching read ports; 0: reads return array contents only

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
ready  out  1  high when the clear sweep is done and the file is usable
rf_wr_en  in  1  writeback write enable
waddr  in  AW  writeback destination
wdata  in  XLEN  writeback data
raddr1  in  AW  read port 1 address
raddr2  in  AW  read port 2 address
rdata1  out  XLEN  read port 1 data (combinational)
rdata2  out  XLEN  read port 2 data (combinational)
iss_en  in  1  issue of an instruction that will write iss_rd
iss_rd  in  AW  destination of the issued instruction
scb_flush  in  1  clear all pending bits (pipeline flush)
rs1_busy  out  1  raddr1 has a pending write not yet retired
rs2_busy  out  1  raddr2 has a pending write not yet retired

Behaviour:
- One clock domain (clk); reset is asynchronous and active-low (rst_n). Asserting rst_n low immediately, independent of clk: state=CLEAR, clr_idx=0, pending=all 0, ready=0.
- FSM states CLEAR and RUN.
- CLEAR: each rising edge writes 0 to rf[clr_idx] and increments clr_idx. On the edge that clears index NREG-1, state goes to RUN and ready goes to 1. ready is therefore low for exactly NREG rising edges after rst_n deasserts.
- In CLEAR: rf_wr_en, iss_en and scb_flush are ignored; rdata1/2=0; rs1/2_busy=0.
- Reset re-asserted mid-sweep or in RUN restarts the sweep from index 0.
- RUN write: if rf_wr_en and not (ZERO_REG and waddr==0), rf[waddr] <= wdata at the edge.
- RUN read, port k:
  - ZERO_REG and raddrk==0 gives 0.
  - Otherwise, BYPASS and rf_wr_en and waddr==raddrk gives wdata.
  - Otherwise, rf[raddrk].
  - Zero-read takes priority over bypass.
- Scoreboard pending[NREG], RUN only, evaluated at each edge in this priority order:
  1. scb_flush: all bits cleared; a same-cycle iss_en is also discarded.
  2. rf_wr_en clears pending[waddr].
  3. iss_en sets pending[iss_rd]. When issue and retire hit the same index in one cycle, the bit stays set (issue wins).
  - With ZERO_REG, pending[0] is never set.
- rsk_busy = pending[raddrk] and not (rf_wr_en and waddr==raddrk). A same-cycle retire unblocks the reader only when BYPASS=1. With BYPASS=0, busy = pending[raddrk] unmodified.
- rsk_busy is forced to 0 when ZERO_REG and raddrk==0.
- No back-pressure: one write, one issue and two reads per cycle, all unconditional.
- Write latency is 1 cycle (visible in the array the cycle after the edge). Bypass latency is 0.

Test Plan:
- Reset sweep: pre-load garbage by forcing the array, pulse rst_n low, release -> ready=0 for exactly 32 edges then 1; all 32 registers read 0; writes attempted during CLEAR are lost.
- Zero register: write waddr=0 wdata=32'hDEADBEEF, then read raddr1=0 -> 0. Issue iss_rd=0 -> rs1_busy stays 0.
- Write/read and bypass: write x5=32'h1234_5678 with raddr2=5 in the same cycle -> rdata2=32'h1234_5678 combinationally (BYPASS=1), and the old value with BYPASS=0. The next cycle reads 32'h1234_5678 in both configurations.
- Scoreboard: issue rd=7, then raddr1=7 -> rs1_busy=1. Retire waddr=7 -> busy 0 in the retire cycle (BYPASS=1), and the register is not pending afterwards.
- Simultaneous issue and retire to rd=9 -> pending[9] remains 1 next cycle. A scb_flush with iss_en rd=3 -> all pending 0, including 3.
- Mid-operation reset: rst_n low with pending bits set and the sweep half done -> ready=0 and busy=0 immediately; the sweep restarts from index 0 and takes the full 32 cycles.

Source files
------------

// File: rtl/ysyx_regfile_sb.sv
// Integer register file with hardwired zero register, optional write bypass,
// post-reset clear sweep and a pending-write scoreboard for RAW detection.
module ysyx_regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            ready,
    input  logic            rf_wr_en,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_rd,
    input  logic            scb_flush,
    output logic            rs1_busy,
    output logic            rs2_busy
);

    // state | meaning
    // CLEAR | sweeping zeros into the array, all requests ignored
    // RUN   | normal read/write/issue operation
    typedef enum logic {CLEAR, RUN} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   clr_idx;
    logic [XLEN-1:0] rf [NREG];
    logic [NREG-1:0] pending, pending_nxt;
    logic            wr_ok, iss_ok;

    assign wr_ok  = rf_wr_en && !((ZERO_REG != 0) && (waddr  == '0));
    assign iss_ok = iss_en   && !((ZERO_REG != 0) && (iss_rd == '0));
    assign ready  = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= CLEAR;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (clr_idx == AW'(NREG - 1)) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              clr_idx <= '0;
        else if (state == CLEAR) clr_idx <= clr_idx + AW'(1);
    end

    // Array has no reset of its own; the sweep is what clears it.
    always_ff @(posedge clk) begin
        if (state == CLEAR) rf[clr_idx] <= '0;
        else if (wr_ok)     rf[waddr]   <= wdata;
    end

    // Issue is applied after retire so a same-index pair leaves the bit set.
    always_comb begin
        pending_nxt = pending;
        if (scb_flush) begin
            pending_nxt = '0;
        end else begin
            if (rf_wr_en) pending_nxt[waddr]  = 1'b0;
            if (iss_ok)   pending_nxt[iss_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            pending <= '0;
        else if (state == RUN) pending <= pending_nxt;
    end

    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] a);
        if (state != RUN)                              return '0;
        if ((ZERO_REG != 0) && (a == '0))              return '0;
        if ((BYPASS != 0) && rf_wr_en && (waddr == a)) return wdata;
        return rf[a];
    endfunction

    function automatic logic busy_port(input logic [AW-1:0] a);
        if (state != RUN)                              return 1'b0;
        if ((ZERO_REG != 0) && (a == '0))              return 1'b0;
        if ((BYPASS != 0) && rf_wr_en && (waddr == a)) return 1'b0;
        return pending[a];
    endfunction

    assign rdata1   = read_port(raddr1);
    assign rdata2   = read_port(raddr2);
    assign rs1_busy = busy_port(raddr1);
    assign rs2_busy = busy_port(raddr2);

endmodule

// File: tb/tb_ysyx_regfile_sb.sv
// Bench for ysyx_regfile_sb: bypass and non-bypass instances share stimulus and
// are compared every cycle against an array/bit-vector reference model.
module tb_ysyx_regfile_sb;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = $clog2(NREG);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            rf_wr_en = 1'b0;
    logic [AW-1:0]   waddr = '0;
    logic [XLEN-1:0] wdata = '0;
    logic [AW-1:0]   raddr1 = '0;
    logic [AW-1:0]   raddr2 = '0;
    logic            iss_en = 1'b0;
    logic [AW-1:0]   iss_rd = '0;
    logic            scb_flush = 1'b0;

    logic            ready_b, ready_n;
    logic [XLEN-1:0] rdata1_b, rdata2_b, rdata1_n, rdata2_n;
    logic            rs1_busy_b, rs2_busy_b, rs1_busy_n, rs2_busy_n;

    ysyx_regfile_sb #(.XLEN(XLEN), .NREG(NREG), .ZERO_REG(1), .BYPASS(1)) u_byp (
        .clk(clk), .rst_n(rst_n), .ready(ready_b),
        .rf_wr_en(rf_wr_en), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1_b), .rdata2(rdata2_b),
        .iss_en(iss_en), .iss_rd(iss_rd), .scb_flush(scb_flush),
        .rs1_busy(rs1_busy_b), .rs2_busy(rs2_busy_b)
    );

    ysyx_regfile_sb #(.XLEN(XLEN), .NREG(NREG), .ZERO_REG(1), .BYPASS(0)) u_nob (
        .clk(clk), .rst_n(rst_n), .ready(ready_n),
        .rf_wr_en(rf_wr_en), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1_n), .rdata2(rdata2_n),
        .iss_en(iss_en), .iss_rd(iss_rd), .scb_flush(scb_flush),
        .rs1_busy(rs1_busy_n), .rs2_busy(rs2_busy_n)
    );

    always #5 clk = ~clk;

    // reference model
    logic [XLEN-1:0] m_rf [NREG];
    bit              m_pend [NREG];
    bit              m_ready;
    int              m_edges;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] exp_rd(input int a, input bit byp);
        if (!m_ready || a == 0) return '0;
        if (byp && rf_wr_en && int'(waddr) == a) return wdata;
        return m_rf[a];
    endfunction

    function automatic logic exp_busy(input int a, input bit byp);
        if (!m_ready || a == 0) return 1'b0;
        if (byp && rf_wr_en && int'(waddr) == a) return 1'b0;
        return m_pend[a];
    endfunction

    task automatic model_reset();
        m_ready = 1'b0;
        m_edges = 0;
        for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
    endtask

    task automatic model_edge();
        if (!m_ready) begin
            m_edges++;
            if (m_edges == NREG) begin
                m_ready = 1'b1;
                for (int i = 0; i < NREG; i++) m_rf[i] = '0;
            end
        end else begin
            if (rf_wr_en && waddr != 0) m_rf[waddr] = wdata;
            if (scb_flush) begin
                for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
            end else begin
                if (rf_wr_en) m_pend[waddr] = 1'b0;
                if (iss_en && iss_rd != 0) m_pend[iss_rd] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("ready_byp", 64'(ready_b), 64'(m_ready));
        chk("ready_nob", 64'(ready_n), 64'(m_ready));
        chk("rdata1_byp", 64'(rdata1_b), 64'(exp_rd(int'(raddr1), 1'b1)));
        chk("rdata2_byp", 64'(rdata2_b), 64'(exp_rd(int'(raddr2), 1'b1)));
        chk("rdata1_nob", 64'(rdata1_n), 64'(exp_rd(int'(raddr1), 1'b0)));
        chk("rdata2_nob", 64'(rdata2_n), 64'(exp_rd(int'(raddr2), 1'b0)));
        chk("busy1_byp", 64'(rs1_busy_b), 64'(exp_busy(int'(raddr1), 1'b1)));
        chk("busy2_byp", 64'(rs2_busy_b), 64'(exp_busy(int'(raddr2), 1'b1)));
        chk("busy1_nob", 64'(rs1_busy_n), 64'(exp_busy(int'(raddr1), 1'b0)));
        chk("busy2_nob", 64'(rs2_busy_n), 64'(exp_busy(int'(raddr2), 1'b0)));
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    // Asserts reset mid-cycle, checks the asynchronous effect, holds across one edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_ready", 64'(ready_b | ready_n), 64'(0));
        chk("rst_busy", 64'({rs1_busy_b, rs2_busy_b, rs1_busy_n, rs2_busy_n}), 64'(0));
        tick();
        rst_n = 1'b1;
    endtask

    task automatic idle();
        rf_wr_en = 1'b0; iss_en = 1'b0; scb_flush = 1'b0;
    endtask

    task automatic sweep_and_count();
        int n;
        n = 0;
        while (!ready_b && n < 3 * NREG) begin
            tick();
            n++;
        end
        chk("sweep_len", 64'(n), 64'(NREG));
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) m_rf[i] = '0;
        model_reset();
        #2;
        do_reset();

        // requests during the sweep must be lost
        rf_wr_en = 1'b1; waddr = 5'd3; wdata = 32'hA5A5_A5A5;
        iss_en = 1'b1; iss_rd = 5'd4; raddr1 = 5'd3; raddr2 = 5'd4;
        sweep_and_count();
        idle();
        for (int i = 0; i < NREG; i++) begin
            raddr1 = AW'(i); raddr2 = AW'(NREG - 1 - i);
            tick();
        end

        // zero register
        rf_wr_en = 1'b1; waddr = 5'd0; wdata = 32'hDEAD_BEEF; raddr1 = 5'd0;
        tick();
        idle(); tick();
        iss_en = 1'b1; iss_rd = 5'd0; tick();
        idle(); tick();
        chk("zero_busy", 64'(rs1_busy_b), 64'(0));

        // write/read with bypass
        rf_wr_en = 1'b1; waddr = 5'd5; wdata = 32'h1234_5678; raddr2 = 5'd5;
        #1;
        chk("byp_same_cycle", 64'(rdata2_b), 64'(32'h1234_5678));
        chk("nob_same_cycle", 64'(rdata2_n), 64'(0));
        tick();
        idle(); tick();
        chk("x5_next_nob", 64'(rdata2_n), 64'(32'h1234_5678));

        // scoreboard: issue, read busy, retire
        iss_en = 1'b1; iss_rd = 5'd7; tick();
        idle(); raddr1 = 5'd7; tick();
        chk("x7_busy", 64'(rs1_busy_b), 64'(1));
        rf_wr_en = 1'b1; waddr = 5'd7; wdata = 32'h0000_0777; tick();
        idle(); tick();

        // issue and retire same index, then flush with issue
        iss_en = 1'b1; iss_rd = 5'd9; rf_wr_en = 1'b1; waddr = 5'd9; wdata = 32'h99; tick();
        idle(); raddr1 = 5'd9; tick();
        chk("x9_issue_wins", 64'(rs1_busy_n), 64'(1));
        iss_en = 1'b1; iss_rd = 5'd3; tick();
        scb_flush = 1'b1; iss_en = 1'b1; iss_rd = 5'd3; raddr2 = 5'd3; tick();
        idle(); tick();
        chk("flush_x3", 64'(rs2_busy_n), 64'(0));

        // mid-sweep reset with pending bits set and data in the array
        for (int i = 1; i < 8; i++) begin
            rf_wr_en = 1'b1; waddr = AW'(i); wdata = $urandom;
            iss_en = 1'b1; iss_rd = AW'(i + 8);
            tick();
        end
        idle(); raddr1 = 5'd10; raddr2 = 5'd12;
        do_reset();
        for (int i = 0; i < NREG / 2; i++) tick();
        iss_en = 1'b1; iss_rd = 5'd10;
        do_reset();
        idle();
        sweep_and_count();

        // randomized traffic, addresses biased to collide
        for (int c = 0; c < 1500; c++) begin
            rf_wr_en  = ($urandom_range(0, 99) < 50);
            waddr     = AW'($urandom_range(0, 11));
            wdata     = $urandom;
            raddr1    = AW'($urandom_range(0, 11));
            raddr2    = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 11));
            iss_en    = ($urandom_range(0, 99) < 40);
            iss_rd    = AW'($urandom_range(0, 11));
            scb_flush = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 299) == 0) do_reset();
            else tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
